pipe_hazard_ctrl: RTL and testbench

Central hazard and redirect controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Combinationally selects operand forwarding for the EX stage.
- Generates load-use stalls and IF/ID and ID/EX flushes.
- Sequences control-flow redirects to the IFU: branch, jump, ecall, mret, fence drain.
- Halts the pipeline on ebreak retirement and keeps stall/flush performance counters.

---
 rtl/pipe_pkg.sv | 50 +++++
 rtl/pipe_fwd_unit.sv | 61 ++++++
 rtl/pipe_hazard_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg
//  Purpose  : Shared definitions for the 5-stage pipeline control path:
//             hazard-controller state encoding, forwarding-select codes,
//             system/fence opcode constants shared with the EXU, and the
//             forwarding-select helper used by the forwarding unit.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_REDIR = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  localparam logic [6:0]  OPC_SYSTEM     = 7'b1110011;
  localparam logic [6:0]  OPC_MISC_MEM   = 7'b0001111;
  localparam logic [11:0] SYS_IMM_ECALL  = 12'h000;
  localparam logic [11:0] SYS_IMM_EBREAK = 12'h001;
  localparam logic [11:0] SYS_IMM_MRET   = 12'h302;

  // MEM wins over WB because it holds the younger value. A load in MEM has
  // no data yet, so it is never a forwarding source.
  function automatic logic [1:0] fwd_select(
    input logic [4:0] rs,
    input logic       mem_valid,
    input logic       mem_reg_wen,
    input logic       mem_mem_ren,
    input logic [4:0] mem_rd,
    input logic       wb_valid,
    input logic       wb_reg_wen,
    input logic [4:0] wb_rd
  );
    if (mem_valid && mem_reg_wen && !mem_mem_ren && (mem_rd != 5'd0) && (mem_rd == rs))
      return FWD_MEM;
    if (wb_valid && wb_reg_wen && (wb_rd != 5'd0) && (wb_rd == rs))
      return FWD_WB;
    return FWD_RF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_fwd_unit
//  Purpose  : Purely combinational EX operand forwarding selection and
//             load-use hazard detection for the ID stage.
//  Ports    : id_*   - ID stage operands and usage flags
//             ex_*   - EX stage operands/destination, load flag
//             mem_*  - MEM destination, write/load flags, bus busy
//             wb_*   - WB destination and write flag
//             fwd_rs1_sel / fwd_rs2_sel - operand source select
//             load_use - ID must stall behind a pending load
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_fwd_unit
  import pipe_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_valid,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_ren,
  input  logic       mem_valid,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_wen,
  input  logic       mem_mem_ren,
  input  logic       mem_busy,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_wen,
  output logic [1:0] fwd_rs1_sel,
  output logic [1:0] fwd_rs2_sel,
  output logic       load_use
);

  logic w_ex_match;
  logic w_mem_match;

  assign fwd_rs1_sel = fwd_select(ex_rs1, mem_valid, mem_reg_wen, mem_mem_ren, mem_rd,
                                  wb_valid, wb_reg_wen, wb_rd);
  assign fwd_rs2_sel = fwd_select(ex_rs2, mem_valid, mem_reg_wen, mem_mem_ren, mem_rd,
                                  wb_valid, wb_reg_wen, wb_rd);

  // x0 is never a real producer, so it never causes a stall.
  assign w_ex_match  = (ex_rd != 5'd0) &&
                       ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));
  assign w_mem_match = (mem_rd != 5'd0) &&
                       ((id_use_rs1 && (mem_rd == id_rs1)) || (id_use_rs2 && (mem_rd == id_rs2)));

  // A load still waiting on the bus in MEM blocks its consumer just like
  // a load sitting in EX.
  assign load_use = id_valid &&
                    ((ex_valid && ex_mem_ren && w_ex_match) ||
                     (mem_valid && mem_mem_ren && mem_busy && w_mem_match));

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Central hazard / redirect controller of the 5-stage pipeline.
//             Forwarding and load-use stalls, IF/ID and ID/EX flushes,
//             redirect sequencing to the IFU (branch, jump, ecall, mret,
//             fence drain), ebreak halt and stall/flush counters.
//  Ports    : clk, rst (async, active high)
//             id_* / ex_* / mem_* / wb_* - pipeline stage status
//             csr_mtvec, csr_mepc        - trap vector / return address
//             fwd_rs1_sel, fwd_rs2_sel   - EX operand source select
//             stall_id, flush_if_id, flush_id_ex - pipeline control
//             redirect_valid/pc/ready    - PC redirect handshake with IFU
//             halted, stall_cnt, flush_cnt - status and counters
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic             ex_fire,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_wen,
  input  logic             ex_mem_ren,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_branch_taken,
  input  logic             ex_is_jump,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_ecall,
  input  logic             ex_mret,
  input  logic             ex_fence,
  input  logic [XLEN-1:0]  csr_mtvec,
  input  logic [XLEN-1:0]  csr_mepc,
  input  logic             mem_valid,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_wen,
  input  logic             mem_mem_ren,
  input  logic             mem_busy,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_wen,
  input  logic             wb_ebreak,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic             stall_id,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_t       r_state;
  hz_state_t       w_next_state;
  logic [XLEN-1:0] r_target;
  logic [XLEN-1:0] w_target_next;
  logic            w_target_load;
  logic            w_accept;
  logic            w_load_use;
  logic            w_cause_fire;
  logic            w_cause_redir;
  logic            w_cause_fence;
  logic [XLEN-1:0] w_cause_tgt;
  logic            w_drained;
  logic            w_unused;

  // Every instruction that writes a loaded value also sets its write
  // enable, so the load flag alone identifies a hazard producer.
  assign w_unused = ex_reg_wen;

  pipe_fwd_unit u_fwd (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_valid    (ex_valid),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_ren  (ex_mem_ren),
    .mem_valid   (mem_valid),
    .mem_rd      (mem_rd),
    .mem_reg_wen (mem_reg_wen),
    .mem_mem_ren (mem_mem_ren),
    .mem_busy    (mem_busy),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_reg_wen  (wb_reg_wen),
    .fwd_rs1_sel (fwd_rs1_sel),
    .fwd_rs2_sel (fwd_rs2_sel),
    .load_use    (w_load_use)
  );

  // Redirect cause priority: ecall > mret > branch/jump > fence.
  assign w_cause_fire  = ex_valid && ex_fire;
  assign w_cause_redir = w_cause_fire && (ex_ecall || ex_mret || ex_branch_taken || ex_is_jump);
  assign w_cause_fence = w_cause_fire && ex_fence && !w_cause_redir;
  assign w_cause_tgt   = ex_ecall ? csr_mtvec :
                         ex_mret  ? csr_mepc  : ex_target;
  assign w_drained     = !mem_valid && !wb_valid && !mem_busy;

  always_comb begin
    w_next_state   = r_state;
    w_target_next  = r_target;
    w_target_load  = 1'b0;
    w_accept       = 1'b0;
    stall_id       = 1'b0;
    flush_if_id    = 1'b0;
    flush_id_ex    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halted         = 1'b0;
    // Outputs must read zero for as long as reset is held, even though the
    // inputs may still be active.
    if (!rst) begin
      unique case (r_state)
        ST_RUN: begin
          stall_id = w_load_use;
          if (w_cause_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = w_cause_tgt;
            flush_if_id    = 1'b1;
            flush_id_ex    = 1'b1;
            if (redirect_ready) begin
              w_accept = 1'b1;
            end else begin
              w_target_load = 1'b1;
              w_target_next = w_cause_tgt;
              w_next_state  = ST_REDIR;
            end
          end else if (w_cause_fence) begin
            flush_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
            w_target_load = 1'b1;
            w_target_next = ex_pc + XLEN'(4);
            w_next_state  = ST_DRAIN;
          end
        end
        ST_REDIR: begin
          redirect_valid = 1'b1;
          redirect_pc    = r_target;
          flush_if_id    = 1'b1;
          flush_id_ex    = 1'b1;
          if (redirect_ready) begin
            w_accept     = 1'b1;
            w_next_state = ST_RUN;
          end
        end
        ST_DRAIN: begin
          stall_id    = 1'b1;
          flush_id_ex = 1'b1;
          if (w_drained) w_next_state = ST_REDIR;
        end
        ST_HALT: begin
          stall_id    = 1'b1;
          flush_if_id = 1'b1;
          halted      = 1'b1;
        end
        default: w_next_state = ST_RUN;
      endcase
      if (wb_ebreak) w_next_state = ST_HALT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_target  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_target_load) r_target <= w_target_next;
      if (stall_id) stall_cnt <= stall_cnt + CNT_W'(1);
      if (w_accept) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Self-checking bench for pipe_hazard_ctrl: directed scenarios
//             plus randomized traffic against a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_use_rs1, id_use_rs2;
  logic [4:0] id_rs1, id_rs2;
  logic ex_valid, ex_fire, ex_reg_wen, ex_mem_ren;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [XLEN-1:0] ex_pc, ex_target, csr_mtvec, csr_mepc;
  logic ex_branch_taken, ex_is_jump, ex_ecall, ex_mret, ex_fence;
  logic mem_valid, mem_reg_wen, mem_mem_ren, mem_busy;
  logic [4:0] mem_rd;
  logic wb_valid, wb_reg_wen, wb_ebreak;
  logic [4:0] wb_rd;
  logic redirect_ready;
  logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
  logic stall_id, flush_if_id, flush_id_ex, redirect_valid, halted;
  logic [XLEN-1:0] redirect_pc;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_fire(ex_fire), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_reg_wen(ex_reg_wen), .ex_mem_ren(ex_mem_ren), .ex_pc(ex_pc),
    .ex_branch_taken(ex_branch_taken), .ex_is_jump(ex_is_jump), .ex_target(ex_target),
    .ex_ecall(ex_ecall), .ex_mret(ex_mret), .ex_fence(ex_fence),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_reg_wen(mem_reg_wen),
    .mem_mem_ren(mem_mem_ren), .mem_busy(mem_busy),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_wen(wb_reg_wen), .wb_ebreak(wb_ebreak),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .stall_id(stall_id), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode flags rather than an encoded state.
  logic m_halt, m_wait_accept, m_drain;
  logic [XLEN-1:0]  m_tgt;
  logic [CNT_W-1:0] m_stall_cnt, m_flush_cnt;

  // Expected outputs for the current cycle.
  logic [1:0] e_fwd1, e_fwd2;
  logic e_stall, e_fifd, e_fidex, e_rv, e_halted, e_accept;
  logic [XLEN-1:0] e_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (mem_valid && mem_reg_wen && !mem_mem_ren && mem_rd != 0 && mem_rd == rs) return 2'd1;
    if (wb_valid && wb_reg_wen && wb_rd != 0 && wb_rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic reads(input logic [4:0] rd);
    return rd != 0 && ((id_use_rs1 && rd == id_rs1) || (id_use_rs2 && rd == id_rs2));
  endfunction

  function automatic logic coin(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic model_reset();
    m_halt = 0; m_wait_accept = 0; m_drain = 0;
    m_tgt = '0; m_stall_cnt = '0; m_flush_cnt = '0;
  endtask

  task automatic model_eval();
    logic hazard;
    e_fwd1 = ref_fwd(ex_rs1);
    e_fwd2 = ref_fwd(ex_rs2);
    e_stall = 0; e_fifd = 0; e_fidex = 0; e_rv = 0; e_halted = 0; e_accept = 0; e_pc = '0;
    hazard = id_valid && ((ex_valid && ex_mem_ren && reads(ex_rd)) ||
                          (mem_valid && mem_mem_ren && mem_busy && reads(mem_rd)));
    if (rst) begin
      // all zero
    end else if (m_halt) begin
      e_stall = 1; e_fifd = 1; e_halted = 1;
    end else if (m_wait_accept) begin
      e_rv = 1; e_pc = m_tgt; e_fifd = 1; e_fidex = 1; e_accept = redirect_ready;
    end else if (m_drain) begin
      e_stall = 1; e_fidex = 1;
    end else begin
      e_stall = hazard;
      if (ex_valid && ex_fire) begin
        if (ex_ecall || ex_mret || ex_branch_taken || ex_is_jump) begin
          e_rv = 1; e_fifd = 1; e_fidex = 1; e_accept = redirect_ready;
          e_pc = ex_ecall ? csr_mtvec : (ex_mret ? csr_mepc : ex_target);
        end else if (ex_fence) begin
          e_fifd = 1; e_fidex = 1;
        end
      end
    end
  endtask

  task automatic model_update();
    m_stall_cnt += CNT_W'(e_stall);
    m_flush_cnt += CNT_W'(e_accept);
    if (wb_ebreak) begin
      m_halt = 1; m_wait_accept = 0; m_drain = 0;
    end else if (m_halt) begin
      // stays halted
    end else if (m_wait_accept) begin
      if (redirect_ready) m_wait_accept = 0;
    end else if (m_drain) begin
      if (!mem_valid && !wb_valid && !mem_busy) begin m_drain = 0; m_wait_accept = 1; end
    end else if (e_rv && !redirect_ready) begin
      m_wait_accept = 1; m_tgt = e_pc;
    end else if (e_fidex && !e_rv) begin
      m_drain = 1; m_tgt = ex_pc + 32'd4;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
    chk("fwd_rs1_sel", 32'(fwd_rs1_sel), 32'(e_fwd1));
    chk("fwd_rs2_sel", 32'(fwd_rs2_sel), 32'(e_fwd2));
    chk("stall_id", 32'(stall_id), 32'(e_stall));
    chk("flush_if_id", 32'(flush_if_id), 32'(e_fifd));
    chk("flush_id_ex", 32'(flush_id_ex), 32'(e_fidex));
    chk("redirect_valid", 32'(redirect_valid), 32'(e_rv));
    if (e_rv) chk("redirect_pc", redirect_pc, e_pc);
    chk("halted", 32'(halted), 32'(e_halted));
    chk("stall_cnt", stall_cnt, m_stall_cnt);
    chk("flush_cnt", flush_cnt, m_flush_cnt);
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    sample();
    adv();
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_valid = 0; ex_fire = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_reg_wen = 0;
    ex_mem_ren = 0; ex_pc = '0; ex_branch_taken = 0; ex_is_jump = 0; ex_target = '0;
    ex_ecall = 0; ex_mret = 0; ex_fence = 0; csr_mtvec = '0; csr_mepc = '0;
    mem_valid = 0; mem_rd = 0; mem_reg_wen = 0; mem_mem_ren = 0; mem_busy = 0;
    wb_valid = 0; wb_rd = 0; wb_reg_wen = 0; wb_ebreak = 0; redirect_ready = 0;
  endtask

  task automatic rand_inputs();
    id_valid = coin(70); id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
    id_use_rs1 = coin(70); id_use_rs2 = coin(50);
    ex_valid = coin(70); ex_fire = coin(70);
    ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
    ex_rd = 5'($urandom_range(0, 3)); ex_reg_wen = coin(70); ex_mem_ren = coin(30);
    ex_pc = $urandom & 32'hFFFF_FFFC; ex_target = $urandom;
    ex_branch_taken = coin(10); ex_is_jump = coin(8); ex_ecall = coin(6);
    ex_mret = coin(6); ex_fence = coin(10);
    csr_mtvec = $urandom; csr_mepc = $urandom;
    mem_valid = coin(60); mem_rd = 5'($urandom_range(0, 3)); mem_reg_wen = coin(70);
    mem_mem_ren = coin(30); mem_busy = coin(25);
    wb_valid = coin(60); wb_rd = 5'($urandom_range(0, 3)); wb_reg_wen = coin(70);
    wb_ebreak = 0; redirect_ready = coin(50);
  endtask

  initial begin
    // Reset state
    idle();
    rst = 1;
    model_reset();
    #2;
    chk("rst_stall_id", 32'(stall_id), 32'd0);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    tick();

    // Load-use: lw x5 in EX, add reading x5 in ID
    ex_valid = 1; ex_mem_ren = 1; ex_reg_wen = 1; ex_rd = 5;
    id_valid = 1; id_rs1 = 5; id_use_rs1 = 1;
    sample(); chk("lu_stall", 32'(stall_id), 32'd1); adv();
    idle();
    mem_valid = 1; mem_rd = 5; mem_reg_wen = 1; mem_mem_ren = 1;
    ex_valid = 1; ex_rs1 = 5; ex_rd = 6; ex_reg_wen = 1;
    sample(); chk("lu_stall_once", 32'(stall_id), 32'd0);
    chk("lu_stall_cnt", stall_cnt, 32'd1); chk("lu_no_fwd_load", 32'(fwd_rs1_sel), 32'd0); adv();
    idle();
    wb_valid = 1; wb_rd = 5; wb_reg_wen = 1; ex_valid = 1; ex_rs1 = 5;
    sample(); chk("lu_fwd_wb", 32'(fwd_rs1_sel), 32'd2); adv();

    // MEM over WB priority, and x0 never forwards
    idle();
    mem_valid = 1; mem_reg_wen = 1; mem_rd = 3; wb_valid = 1; wb_reg_wen = 1; wb_rd = 3;
    ex_valid = 1; ex_rs1 = 3;
    sample(); chk("fwd_mem_prio", 32'(fwd_rs1_sel), 32'd1); adv();
    mem_rd = 0; wb_rd = 0; ex_rs1 = 0;
    sample(); chk("fwd_x0", 32'(fwd_rs1_sel), 32'd0); adv();

    // Taken branch held off by the IFU for two cycles
    idle();
    ex_valid = 1; ex_fire = 1; ex_branch_taken = 1; ex_target = 32'h8000_0040;
    sample(); chk("br_pc0", redirect_pc, 32'h8000_0040); adv();
    idle();
    sample(); chk("br_pc1", redirect_pc, 32'h8000_0040); chk("br_fl1", 32'(flush_if_id), 32'd1); adv();
    redirect_ready = 1;
    sample(); chk("br_pc2", redirect_pc, 32'h8000_0040); chk("br_rv2", 32'(redirect_valid), 32'd1); adv();
    idle();
    sample(); chk("br_rv_done", 32'(redirect_valid), 32'd0); chk("br_flush_cnt", flush_cnt, 32'd1); adv();

    // ecall beats a taken branch
    ex_valid = 1; ex_fire = 1; ex_ecall = 1; ex_branch_taken = 1;
    ex_target = 32'h8000_0040; csr_mtvec = 32'h8000_0100; redirect_ready = 1;
    sample(); chk("ecall_pc", redirect_pc, 32'h8000_0100); adv();
    idle();
    tick();

    // fence with a busy bus for 4 cycles
    ex_valid = 1; ex_fire = 1; ex_fence = 1; ex_pc = 32'h8000_0010; mem_busy = 1;
    sample(); chk("fence_flush", 32'(flush_id_ex), 32'd1); adv();
    idle();
    mem_busy = 1;
    for (int i = 0; i < 4; i++) begin
      sample(); chk("drain_stall", 32'(stall_id), 32'd1); adv();
    end
    mem_busy = 0;
    sample(); chk("drain_last", 32'(redirect_valid), 32'd0); adv();
    redirect_ready = 1;
    sample(); chk("fence_pc", redirect_pc, 32'h8000_0014); chk("fence_rv", 32'(redirect_valid), 32'd1); adv();
    idle();
    tick();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      tick();
    end

    // ebreak while a redirect is pending
    idle();
    redirect_ready = 1;
    tick();
    idle();
    ex_valid = 1; ex_fire = 1; ex_branch_taken = 1; ex_target = 32'h8000_0040;
    tick();
    idle();
    wb_ebreak = 1;
    sample(); chk("ebk_redir", 32'(redirect_valid), 32'd1); adv();
    wb_ebreak = 0;
    sample(); chk("halt_halted", 32'(halted), 32'd1); chk("halt_rv", 32'(redirect_valid), 32'd0); adv();
    redirect_ready = 1; ex_valid = 1; ex_fire = 1; ex_ecall = 1;
    tick();

    // Asynchronous reset mid-cycle
    #2;
    rst = 1;
    #1;
    chk("arst_stall_id", 32'(stall_id), 32'd0);
    chk("arst_flush_if_id", 32'(flush_if_id), 32'd0);
    chk("arst_flush_id_ex", 32'(flush_id_ex), 32'd0);
    chk("arst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("arst_halted", 32'(halted), 32'd0);
    chk("arst_stall_cnt", stall_cnt, 32'd0);
    chk("arst_flush_cnt", flush_cnt, 32'd0);
    model_reset();
    idle();
    @(posedge clk); #1;
    rst = 0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
